// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO bus responder.
// Register offsets are word indices into addr[4:2].
package gpio_pkg;

   localparam logic [31:0] gpio_base_addr = 32'h4000_0000;

   localparam logic [2:0] gpio_data_out = 3'd0;
   localparam logic [2:0] gpio_dir      = 3'd1;
   localparam logic [2:0] gpio_data_in  = 3'd2;
   localparam logic [2:0] gpio_irq_en   = 3'd3;
   localparam logic [2:0] gpio_irq_pend = 3'd4;
   localparam logic [2:0] gpio_edge_sel = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } gpio_state_t;

   // Expand 4 byte strobes into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      strb_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop input synchroniser, previous-value register and edge detector.
// Edges are masked until a short post-reset arming count completes.
module gpio_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin,
   input  logic [WIDTH-1:0] edge_sel,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] edges
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [1:0]       arm_cnt;
   logic             armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         prev    <= '0;
         arm_cnt <= 2'd0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         prev  <= sync2;
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      end
   end

   // Pins high at reset ripple through sync2/prev while still unarmed.
   assign armed = (arm_cnt == 2'd3);
   assign sync  = sync2;
   assign edges = armed ? ((sync2 & ~prev & ~edge_sel) | (~sync2 & prev & edge_sel))
                        : '0;

endmodule

// File: rtl/gpio.sv
// Memory-mapped GPIO responder: output/direction registers, synchronised
// inputs and an edge-triggered level interrupt, answering one-cycle valid/ready.
module gpio
   import gpio_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gpio_valid,
   input  logic             gpio_instr,
   input  logic [31:0]      gpio_addr,
   input  logic [31:0]      gpio_wdata,
   input  logic [3:0]       gpio_wstrb,
   output logic [31:0]      gpio_rdata,
   output logic             gpio_ready,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             gpio_irpt
);

   // Handshake: a request is taken on any edge where state is IDLE and
   // gpio_valid=1; gpio_ready is then high for exactly the following cycle
   // with gpio_rdata, and gpio_valid is ignored during that RESP cycle.

   gpio_state_t state;
   gpio_state_t state_nxt;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_en;
   logic [WIDTH-1:0] irq_pend;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] sync_val;
   logic [WIDTH-1:0] edges;
   logic [31:0]      rdata_q;
   logic [31:0]      rd_val;
   logic [31:0]      bmask;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] wbits;
   logic [WIDTH-1:0] w1c_mask;
   logic [2:0]       reg_sel;
   logic             accept;
   logic             is_wr;
   logic             unused_bits;

   // Fetches are plain reads; only addr[4:2] selects a register.
   assign unused_bits = ^{gpio_instr, gpio_addr, gpio_wdata};

   assign reg_sel  = gpio_addr[4:2];
   assign accept   = (state == IDLE) && gpio_valid;
   assign is_wr    = |gpio_wstrb;
   assign bmask    = strb_mask(gpio_wstrb);
   assign wmask    = bmask[WIDTH-1:0];
   assign wbits    = gpio_wdata[WIDTH-1:0];
   assign w1c_mask = (accept && is_wr && reg_sel == gpio_irq_pend) ? (wbits & wmask) : '0;

   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                              input logic [WIDTH-1:0] new_v,
                                              input logic [WIDTH-1:0] m);
      merge = (old_v & ~m) | (new_v & m);
   endfunction

   gpio_sync #(.WIDTH(WIDTH)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .pin      (gpio_in),
      .edge_sel (edge_sel),
      .sync     (sync_val),
      .edges    (edges)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gpio_valid) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gpio_ready = (state == RESP);
      gpio_rdata = gpio_ready ? rdata_q : 32'd0;
   end

   always_comb begin
      rd_val = 32'd0;
      case (reg_sel)
         gpio_data_out: rd_val[WIDTH-1:0] = data_out;
         gpio_dir:      rd_val[WIDTH-1:0] = dir;
         gpio_data_in:  rd_val[WIDTH-1:0] = sync_val;
         gpio_irq_en:   rd_val[WIDTH-1:0] = irq_en;
         gpio_irq_pend: rd_val[WIDTH-1:0] = irq_pend;
         gpio_edge_sel: rd_val[WIDTH-1:0] = edge_sel;
         default:       rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         dir       <= '0;
         irq_en    <= '0;
         irq_pend  <= '0;
         edge_sel  <= '0;
         rdata_q   <= 32'd0;
         gpio_irpt <= 1'b0;
      end else begin
         if (accept) begin
            rdata_q <= is_wr ? 32'd0 : rd_val;
            if (is_wr) begin
               case (reg_sel)
                  gpio_data_out: data_out <= merge(data_out, wbits, wmask);
                  gpio_dir:      dir      <= merge(dir, wbits, wmask);
                  gpio_irq_en:   irq_en   <= merge(irq_en, wbits, wmask);
                  gpio_edge_sel: edge_sel <= merge(edge_sel, wbits, wmask);
                  default:       ;
               endcase
            end
         end
         // A fresh edge in the same cycle as a clear keeps the bit set.
         irq_pend  <= (irq_pend & ~w1c_mask) | edges;
         gpio_irpt <= |(irq_pend & irq_en);
      end
   end

   assign gpio_out = data_out;
   assign gpio_oe  = dir;

endmodule

// File: doc/gpio.md
Name: gpio

Overview:
- Memory-mapped GPIO responder on the CPU data/instruction bus, a peer of the bram, uart and timer responders.
- The top-level decoder drives gpio_valid when the address falls in the GPIO window.
- The block answers on the valid/ready protocol, drives output pins and tri-state enables, and synchronises input pins.
- It raises a level interrupt on selected input edges.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32). Register bits at and above WIDTH read 0 and ignore writes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- gpio_valid  in  1  request strobe from the bus decoder
- gpio_instr  in  1  instruction-fetch flag; ignored, fetch treated as read
- gpio_addr  in  32  byte address; only bits [4:2] are decoded
- gpio_wdata  in  32  write data
- gpio_wstrb  in  4  byte write strobes; 0 = read
- gpio_rdata  out  32  read data, valid only while gpio_ready=1
- gpio_ready  out  1  single-cycle response strobe
- gpio_in  in  WIDTH  asynchronous input pins
- gpio_out  out  WIDTH  output pin values (DATA_OUT register)
- gpio_oe  out  WIDTH  output enables (DIR register, 1 = drive)
- gpio_irpt  out  1  registered interrupt request to the CPU

Behaviour:
- Register map, offset = addr[4:2]*4:
  - 0x00 DATA_OUT: RW
  - 0x04 DIR: RW
  - 0x08 DATA_IN: RO, synchronised pins
  - 0x0C IRQ_EN: RW
  - 0x10 IRQ_PEND: read / write-1-to-clear
  - 0x14 EDGE_SEL: RW, 0 = rising, 1 = falling
  - 0x18, 0x1C: read 0, writes ignored, ready still returned
- Bus FSM, two states:
  - IDLE: if gpio_valid=1, sample addr/wdata/wstrb, perform the write or latch read data into a rdata register, go to RESP.
  - RESP: gpio_ready=1 and gpio_rdata driven for exactly one cycle; gpio_valid is ignored; always return to IDLE.
  - Latency: request accepted at edge N, ready high during cycle N to N+1.
  - A requester holding valid until ready gets exactly one transaction. Valid still high in the IDLE cycle after RESP is a new request.
- gpio_rdata = 0 whenever gpio_ready=0. Write responses return rdata = 0.
- Writes honour wstrb per byte. A partial write to IRQ_PEND clears only 1-bits in the enabled bytes.
- Input path: two-flop synchroniser sync1 -> sync2, then prev <= sync2.
  - Rising edge = sync2 & ~prev & ~EDGE_SEL.
  - Falling edge = ~sync2 & prev & EDGE_SEL.
  - A pin change before edge N is visible in sync2 after edge N+1, sets IRQ_PEND at edge N+2, and raises gpio_irpt at edge N+3.
- Pending update: pend <= (pend & ~w1c_mask) | edge. If a W1C and a new edge hit the same bit in the same cycle, set wins.
- gpio_irpt <= |(IRQ_PEND & IRQ_EN), registered.
  - Clearing IRQ_EN or IRQ_PEND drops gpio_irpt one cycle after the write edge.
- Post-reset arming:
  - A 2-bit saturating counter reset to 0 counts to 3.
  - Edge detection is masked until the counter reaches 3.
  - Pins already high at reset therefore never create a spurious pending bit.
- Reset:
  - FSM = IDLE; gpio_ready = 0; gpio_rdata = 0; gpio_irpt = 0.
  - DATA_OUT, DIR, IRQ_EN, IRQ_PEND, EDGE_SEL, sync1, sync2, prev and arming counter all cleared.
  - gpio_out = 0 and gpio_oe = 0: all pins start as inputs.
- Reset asserted mid-transaction, including in RESP, aborts it: no ready, and any pending write is lost.
- Reads of DATA_IN return sync2 for every pin regardless of DIR.

Decomposition:
- configure package holds:
  - gpio_base_addr
  - register offset constants gpio_data_out, gpio_dir, gpio_data_in, gpio_irq_en, gpio_irq_pend, gpio_edge_sel
  - FSM state typedef (IDLE/RESP)
- One natural sub-module, gpio_sync: the WIDTH-wide two-flop synchroniser plus prev register and edge detector. It exports sync value and edge vector.
- Top-level integration adds one decode branch and a gpio_ready term in the rdata/ready mux; that is outside this block.

Test Plan:
- Write DATA_OUT=0xA5A5_5A5A with wstrb=4'b1111, then write DIR=0xFFFF_0000 -> ready 1 cycle after each valid; gpio_out=0xA5A5_5A5A; gpio_oe=0xFFFF_0000; read-back returns the same values.
- Byte write wstrb=4'b0100, wdata=0x00CC_0000 onto DATA_OUT=0x1122_3344 -> DATA_OUT=0x11CC_3344.
- Drive gpio_in[3] 0->1 with IRQ_EN=0x8 and EDGE_SEL=0 -> IRQ_PEND=0x8 two edges later and gpio_irpt=1 three edges later. Write 0x8 to IRQ_PEND -> pend 0 and gpio_irpt=0 next cycle.
- EDGE_SEL[3]=1 with gpio_in[3] rising -> no pending. A later falling edge -> IRQ_PEND[3]=1.
- W1C of bit 3 in the same cycle a new rising edge on pin 3 is detected -> IRQ_PEND[3] remains 1.
- Hold gpio_in=0xFFFF_FFFF through reset release -> IRQ_PEND stays 0; DATA_IN reads 0xFFFF_FFFF after 2 cycles. Also: valid held high 4 cycles -> exactly 2 ready pulses; reset asserted during RESP -> gpio_ready=0 next cycle.
